// File: rtl/onectr_pkg.sv
// ----------------------------------------------------------------------------
// onectr_pkg
// Shared types and constants for the one-counter processor control path.
//   seq_state_t        sequencer state: IDLE, RUN, DONE
//   PCSIZE_DEFAULT     default program counter width
//   MAXCYCLES_DEFAULT  default watchdog limit in RUN cycles
//   WDOG_W             width of the RUN-cycle watchdog counter
// ----------------------------------------------------------------------------
package onectr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int PCSIZE_DEFAULT    = 8;
    localparam int MAXCYCLES_DEFAULT = 1023;
    localparam int WDOG_W            = 16;

endpackage

// File: rtl/onectr_sequencer.sv
// ----------------------------------------------------------------------------
// onectr_sequencer
// Program-flow controller for the one-counter processor. Owns the program
// counter, runs the start/done handshake, resolves jumps decoded from the
// current instruction, gates the register-file write enable and stops
// runaway programs with a RUN-cycle watchdog.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-low
//   start_i      in   start request, honoured in IDLE/DONE only
//   JP           in   unconditional jump (current instruction)
//   JF           in   jump-if-flag (current instruction)
//   Halt         in   end-of-program marker (current instruction)
//   Flag         in   datapath condition flag
//   JumpAddress  in   jump target (current instruction)
//   Wen_i        in   decoder register-file write enable
//   Wen          out  gated write enable to the datapath (combinational)
//   PCAddress    out  instruction ROM address (registered)
//   busy_o       out  high while a program runs
//   done_o       out  one-cycle pulse on normal completion
//   err_o        out  sticky watchdog / PC-overflow error
// ----------------------------------------------------------------------------
module onectr_sequencer
    import onectr_pkg::*;
#(
    parameter int PCSIZE    = PCSIZE_DEFAULT,
    parameter int MAXCYCLES = MAXCYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              JP,
    input  logic              JF,
    input  logic              Halt,
    input  logic              Flag,
    input  logic [PCSIZE-1:0] JumpAddress,
    input  logic              Wen_i,
    output logic              Wen,
    output logic [PCSIZE-1:0] PCAddress,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // Counter value seen during the last permitted RUN cycle.
    localparam logic [WDOG_W-1:0] LP_CYC_LAST = WDOG_W'(MAXCYCLES - 1);

    typedef struct packed {
        logic [PCSIZE-1:0] pc;
        logic              wrap;   // sequential step overflowed the PC
    } next_pc_t;

    // Jump resolution: JP beats JF, JF needs Flag, otherwise step by one.
    // A jump never counts as a wrap, even when it targets address 0.
    function automatic next_pc_t f_next_pc(
        input logic [PCSIZE-1:0] pc,
        input logic              jp,
        input logic              jf,
        input logic              flag,
        input logic [PCSIZE-1:0] jaddr
    );
        next_pc_t r;
        r.wrap = 1'b0;
        if (jp || (jf && flag)) begin
            r.pc = jaddr;
        end else begin
            r.pc   = pc + PCSIZE'(1);
            r.wrap = &pc;
        end
        return r;
    endfunction

    seq_state_t        r_state;
    logic [PCSIZE-1:0] r_pc;
    logic [WDOG_W-1:0] r_cyc;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    next_pc_t          w_next;

    assign w_next = f_next_pc(r_pc, JP, JF, Flag, JumpAddress);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values; blocking here would make r_done and
    // r_state ordering-dependent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                        r_cyc   <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_cyc <= r_cyc + WDOG_W'(1);
                    if (Halt) begin
                        // PC holds on the halt instruction.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_cyc == LP_CYC_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_pc <= w_next.pc;
                        if (w_next.wrap) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Halt instructions never write; nothing writes outside RUN.
    assign Wen       = Wen_i && (r_state == RUN) && !Halt;
    assign PCAddress = r_pc;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_onectr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_onectr_sequencer
// Drives onectr_sequencer from an instruction ROM held in the bench. Each
// cycle the driver presents the instruction at the reference model's PC,
// pushes the outputs the model expects for that cycle into a scoreboard, then
// advances the model. A monitor pops one record per cycle on the falling edge
// and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_onectr_sequencer;

    localparam int PCS     = 6;
    localparam int MAXC    = 100;
    localparam int ROM_N   = 1 << PCS;
    localparam int PC_LAST = ROM_N - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           JP;
    logic           JF;
    logic           Halt;
    logic           Flag;
    logic [PCS-1:0] JumpAddress;
    logic           Wen_i;
    logic           Wen;
    logic [PCS-1:0] PCAddress;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    always #5 clk = ~clk;

    onectr_sequencer #(
        .PCSIZE    (PCS),
        .MAXCYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .JP          (JP),
        .JF          (JF),
        .Halt        (Halt),
        .Flag        (Flag),
        .JumpAddress (JumpAddress),
        .Wen_i       (Wen_i),
        .Wen         (Wen),
        .PCAddress   (PCAddress),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    typedef struct {
        bit jp;
        bit jf;
        bit halt;
        bit flag;
        bit wen;
        int jaddr;
    } inst_t;

    typedef struct {
        int pc;
        bit busy;
        bit done;
        bit err;
        bit wen;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_t;

    inst_t  rom [ROM_N];
    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: program position, RUN cycles spent, pulse/error flags.
    mmode_t m_mode;
    int     m_pc;
    int     m_steps;
    bit     m_done;
    bit     m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 0;
        m_steps = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the program-flow rules.
    task automatic model_step(input bit r, input bit s, input inst_t in);
        if (!r) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (m_mode != M_RUN) begin
            if (s) begin
                m_mode  = M_RUN;
                m_pc    = 0;
                m_steps = 0;
                m_err   = 1'b0;
            end else begin
                m_mode = M_IDLE;
            end
        end else begin
            m_steps++;
            if (in.halt) begin
                m_mode = M_DONE;
                m_done = 1'b1;
            end else if (m_steps == MAXC) begin
                m_mode = M_DONE;
                m_err  = 1'b1;
            end else if (in.jp || (in.jf && in.flag)) begin
                m_pc = in.jaddr;
            end else if (m_pc == PC_LAST) begin
                m_pc   = 0;
                m_err  = 1'b1;
                m_mode = M_DONE;
            end else begin
                m_pc++;
            end
        end
    endtask

    // One bench cycle: present inputs just after the edge, record what the
    // DUT must show during this cycle, then move the model past the next edge.
    task automatic cycle(input bit r, input bit s);
        inst_t in;
        exp_t  e;
        @(posedge clk);
        #1;
        in          = rom[m_pc];
        rst         = r;
        start_i     = s;
        JP          = in.jp;
        JF          = in.jf;
        Halt        = in.halt;
        Flag        = in.flag;
        JumpAddress = PCS'(in.jaddr);
        Wen_i       = in.wen;
        e.pc   = m_pc;
        e.busy = (m_mode == M_RUN);
        e.done = m_done;
        e.err  = m_err;
        e.wen  = in.wen && (m_mode == M_RUN) && !in.halt;
        sb.push_back(e);
        model_step(r, s, in);
    endtask

    task automatic clear_rom(input bit wen_all);
        for (int i = 0; i < ROM_N; i++) begin
            rom[i].jp    = 1'b0;
            rom[i].jf    = 1'b0;
            rom[i].halt  = 1'b0;
            rom[i].flag  = 1'b0;
            rom[i].wen   = wen_all;
            rom[i].jaddr = 0;
        end
    endtask

    task automatic random_rom();
        for (int i = 0; i < ROM_N; i++) begin
            rom[i].jp    = ($urandom_range(9) == 0);
            rom[i].jf    = ($urandom_range(5) == 0);
            rom[i].halt  = ($urandom_range(11) == 0);
            rom[i].flag  = $urandom_range(1);
            rom[i].wen   = $urandom_range(1);
            rom[i].jaddr = $urandom_range(PC_LAST);
        end
    endtask

    // Start a program and clock it until the model leaves RUN.
    task automatic run_prog(input bit hold_start, input int post_idle);
        int budget;
        cycle(1'b1, 1'b1);
        budget = 0;
        while (m_mode == M_RUN && budget < 4 * MAXC) begin
            cycle(1'b1, hold_start);
            budget++;
        end
        repeat (post_idle) cycle(1'b1, 1'b0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("PCAddress", 32'(PCAddress), e.pc);
                check("busy_o",    32'(busy_o),    32'(e.busy));
                check("done_o",    32'(done_o),    32'(e.done));
                check("err_o",     32'(err_o),     32'(e.err));
                check("Wen",       32'(Wen),       32'(e.wen));
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0; start_i = 1'b0; JP = 1'b0; JF = 1'b0; Halt = 1'b0;
        Flag = 1'b0; JumpAddress = '0; Wen_i = 1'b0;
        clear_rom(1'b1);
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state, then a short idle stretch.
        cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);

        // Linear program halting at PC 5, write enable held high throughout.
        rom[5].halt = 1'b1;
        run_prog(1'b0, 3);

        // Conditional jump at PC 3, taken then not taken.
        clear_rom(1'b1);
        rom[3].jf = 1'b1; rom[3].flag = 1'b1; rom[3].jaddr = 'h10;
        rom['h10].halt = 1'b1;
        rom[4].halt = 1'b1;
        run_prog(1'b0, 2);
        rom[3].flag = 1'b0;
        run_prog(1'b0, 2);

        // JP and JF together: JP wins even with Flag low.
        rom[3].jp = 1'b1; rom[3].jaddr = 'h20;
        rom['h20].halt = 1'b1;
        run_prog(1'b0, 2);

        // Watchdog: jump to self at PC 2, then a clean run clears err_o.
        clear_rom(1'b0);
        rom[2].jp = 1'b1; rom[2].jaddr = 2;
        run_prog(1'b0, 3);
        clear_rom(1'b1);
        rom[1].halt = 1'b1;
        run_prog(1'b0, 1);

        // PC overflow with no jumps and no halt.
        clear_rom(1'b0);
        run_prog(1'b0, 3);

        // Reset at PC 7 while start_i is held high.
        clear_rom(1'b1);
        rom[20].halt = 1'b1;
        cycle(1'b1, 1'b1);
        budget = 0;
        while (m_pc != 7 && m_mode == M_RUN && budget < 50) begin
            cycle(1'b1, 1'b1);
            budget++;
        end
        cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0);

        // Back-to-back runs: restart straight out of DONE.
        clear_rom(1'b1);
        rom[2].halt = 1'b1;
        run_prog(1'b1, 0);
        run_prog(1'b1, 0);
        run_prog(1'b0, 2);

        // Random programs, random start holding and gaps.
        for (int n = 0; n < 40; n++) begin
            random_rom();
            run_prog(1'(($urandom_range(1))), $urandom_range(2));
            if ($urandom_range(7) == 0) begin
                cycle(1'b0, 1'(($urandom_range(1))));
            end
        end

        repeat (3) cycle(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onectr_sequencer.md
# onectr_sequencer

Program-flow controller for the one-counter processor without memory. Owns the program counter, handles the start/done handshake with the surrounding system, and resolves the jump controls decoded from the current instruction. It also gates the datapath register-file write enable, and aborts runaway programs with a cycle watchdog. It sits between the instruction ROM, which is addressed by `PCAddress`, and the datapath, which supplies the condition flag.

## Interface
- `PCSIZE`, 8, program counter width
- `MAXCYCLES`, 1023, watchdog limit in RUN cycles; ≥1, fits in 16 bits
- `clk  in  1`  system clock, all logic on rising edge
- `rst  in  1`  synchronous reset, active-low
- `start_i  in  1`  start request, sampled in IDLE/DONE only
- `JP  in  1`  unconditional jump, decoded from current instruction
- `JF  in  1`  jump-if-flag, decoded from current instruction
- `Halt  in  1`  end-of-program marker, decoded from current instruction
- `Flag  in  1`  datapath condition flag (last ALU result zero)
- `JumpAddress  in  PCSIZE`  jump target from current instruction
- `Wen_i  in  1`  register-file write enable from decoder
- `Wen  out  1`  gated write enable to datapath
- `PCAddress  out  PCSIZE`  instruction address (registered)
- `busy_o  out  1`  high while RUN
- `done_o  out  1`  one-cycle pulse on normal completion
- `err_o  out  1`  sticky watchdog/overflow error, cleared by next accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start_i=1`: go to RUN, PC←0, cycle count←0, `err_o`←0.
  - Otherwise hold.
- RUN, evaluated each cycle in priority order:
  1. `Halt=1`: go to DONE, pulse `done_o`. The PC holds.
  2. Cycle count = MAXCYCLES−1: go to DONE, set `err_o`. No `done_o`.
  3. `JP=1`: PC←JumpAddress.
  4. `JF=1` and `Flag=1`: PC←JumpAddress.
  5. Otherwise, if PC = 2^PCSIZE−1: PC wraps to 0, set `err_o`, go to DONE. No `done_o`.
  6. Otherwise PC←PC+1.
- `JP` and `JF` both high: `JP` wins.
- `JF=1` with `Flag=0` falls through to PC+1.
- Cycle counter increments on every RUN cycle. It is 16 bits and never wraps, because RUN ends first.
- DONE:
  - `start_i=1` restarts exactly as from IDLE (back-to-back runs allowed).
  - Otherwise go to IDLE next cycle.
- `start_i` during RUN is ignored; no queueing.
- `Wen = Wen_i & (state==RUN) & ~Halt`. Halt instructions never write. No writes occur outside RUN.

## Timing
- Reset values: state IDLE, `PCAddress`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `Wen`=0.
- Reset has priority over every other event, including mid-RUN. It clears the run with no `done_o` and no error.
- `PCAddress`, `busy_o`, `done_o` and `err_o` are registered. `Wen` is combinational from `Wen_i`, `Halt` and state.
- ROM read is combinational: the instruction at `PCAddress` drives `JP`/`JF`/`Halt`/`JumpAddress`/`Wen_i` in the same cycle. The PC update takes effect at the next edge, so there is one instruction per cycle.
- Start latency: `start_i` high at edge k gives `busy_o`=1 and `PCAddress`=0 after edge k.
- Completion: `Halt` seen at edge n gives `done_o`=1 and `busy_o`=0 after edge n, for exactly one cycle.
- A run of N instructions including the halt keeps `busy_o` high for N cycles.

## Structure
- Shared package `onectr_pkg`:
  - `seq_state_t` enum {IDLE, RUN, DONE}
  - `PCSIZE` default constant
  - watchdog width constant (16)
- No sub-module needed. Single FSM plus PC and cycle registers. Next-PC selection is a local function.

## Test plan
- Linear program: start, `Halt` at PC=5 → PCAddress 0..5, `busy_o` 6 cycles, `done_o` one pulse, `err_o`=0.
- Conditional jump:
  - At PC=3: `JF`=1, `Flag`=1, `JumpAddress`=0x10 → next PC 0x10.
  - Repeat with `Flag`=0 → next PC 4.
  - `JP` and `JF` both high with `JumpAddress`=0x20 → 0x20.
- Watchdog: `MAXCYCLES`=8, `JP` to self at PC=2 → `err_o`=1 after 8 RUN cycles, no `done_o`, state DONE then IDLE. The next start clears `err_o`.
- PC wrap: `PCSIZE`=4, no jumps, no halt → after PC=15, `err_o`=1, `busy_o`=0, `PCAddress` reads 0.
- Reset mid-RUN: `rst`=0 at PC=7 → next cycle PC=0, IDLE, all outputs 0. `start_i` held high in RUN is ignored.
- Write gating: `Wen_i`=1 held constant → `Wen`=1 only in RUN cycles without `Halt`, 0 in IDLE/DONE. Back-to-back start in DONE restarts at PC=0 the next cycle.
